serial_alu_sequencer: RTL and testbench

SERIAL_ALU_SEQUENCER -- requirements
Module: serial_alu_sequencer

---
 rtl/alu_defs.sv | 29 ++
 rtl/alu_bit_step.sv | 42 ++++
 rtl/serial_alu_sequencer.sv | 112 +++++++++++
 tb/tb_serial_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared encodings for the bit-serial ALU: control word layout, named
// operations and sequencer states.
package alu_defs;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic [1:0] operation;
    } alu_ctl_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit_step.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR,
// full adder, Less passthrough and the MSB Set/Overflow terms.
module alu_bit_step
    import alu_defs::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       carry_in,
    input  logic       less,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out,
    output logic       set,
    output logic       overflow
);

    logic a_mux;
    logic b_mux;
    logic sum;

    assign a_mux     = a ^ ainvert;
    assign b_mux     = b ^ binvert;
    assign sum       = a_mux ^ b_mux ^ carry_in;
    assign carry_out = (a_mux & b_mux) | (carry_in & (a_mux ^ b_mux));
    assign overflow  = carry_in ^ carry_out;
    assign set       = overflow ^ sum;

    // NOTE: the default arm keeps this mux purely combinational; an
    // incomplete case in always_comb would infer a latch.
    always_comb begin
        unique case (operation)
            OP_AND:  result = a_mux & b_mux;
            OP_OR:   result = a_mux | b_mux;
            OP_ADD:  result = sum;
            OP_SLT:  result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU: one shared 1-bit slice walks the operands LSB first,
// one bit per clock, and reports the registered result with a done pulse.
module serial_alu_sequencer
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    alu_ctl_t         ctl_reg;
    logic             accept;
    logic             last_bit;
    logic             slice_result;
    logic             slice_carry;
    logic             slice_set;
    logic             slice_overflow;
    logic [WIDTH-1:0] final_result;

    assign ready    = (state == ST_IDLE);
    assign done     = (state == ST_DONE);
    assign accept   = ready && start && !reset;
    assign last_bit = (count == CW'(WIDTH - 1));

    alu_bit_step u_slice (
        .a         (a_reg[count]),
        .b         (b_reg[count]),
        .ainvert   (ctl_reg.ainvert),
        .binvert   (ctl_reg.binvert),
        .carry_in  (carry),
        .less      (1'b0),
        .operation (ctl_reg.operation),
        .result    (slice_result),
        .carry_out (slice_carry),
        .set       (slice_set),
        .overflow  (slice_overflow)
    );

    // SLT drops every slice bit and keeps only the sign of the MSB compare.
    assign final_result = (ctl_reg.operation == OP_SLT)
                        ? {{(WIDTH-1){1'b0}}, slice_set}
                        : {slice_result, result[WIDTH-2:0]};

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: operand/control holding registers are deliberately left out of
    // reset; they are always reloaded on accept before being consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            ctl_reg <= alu_ctl_t'(alu_ctl);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            carry    <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else if (accept) begin
            count <= '0;
            carry <= alu_ctl[2];
        end else if (state == ST_RUN) begin
            carry <= slice_carry;
            count <= count + CW'(1);
            if (last_bit) begin
                result   <= final_result;
                zero     <= (final_result == '0);
                overflow <= slice_overflow;
            end else begin
                result[count] <= slice_result;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer: a reference model fills a
// scoreboard at issue time and a done-driven monitor drains it.
module tb_serial_alu_sequencer;
    import alu_defs::*;

    localparam int WIDTH = 32;
    localparam int BUDGET = 100;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_ctl;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    exp_t sb[$];
    exp_t mon_exp;
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   pushed = 0;
    int   cycle = 0;
    int   last_done_cycle = -1;
    int   done_interval = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .alu_ctl  (alu_ctl),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: two's-complement arithmetic on the possibly
    // inverted operands, MSB carries taken from 31- and 32-bit partial sums.
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tc);
        exp_t        e;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [32:0] full;
        logic [31:0] low;
        logic        ovf;
        logic        set_bit;
        aa      = tc[3] ? ~ta : ta;
        bb      = tc[2] ? ~tb : tb;
        full    = {1'b0, aa} + {1'b0, bb} + {32'd0, tc[2]};
        low     = {1'b0, aa[30:0]} + {1'b0, bb[30:0]} + {31'd0, tc[2]};
        ovf     = low[31] ^ full[32];
        set_bit = ovf ^ full[31];
        case (tc[1:0])
            2'b00:   e.result = aa & bb;
            2'b01:   e.result = aa | bb;
            2'b10:   e.result = full[31:0];
            default: e.result = {31'd0, set_bit};
        endcase
        e.zero     = (e.result == 32'd0);
        e.overflow = ovf;
        return e;
    endfunction

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (last_done_cycle >= 0) done_interval = cycle - last_done_cycle;
            last_done_cycle = cycle;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("result", 64'(result), 64'(mon_exp.result));
                check("zero", 64'(zero), 64'(mon_exp.zero));
                check("overflow", 64'(overflow), 64'(mon_exp.overflow));
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tc);
        int n = 0;
        while (ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", 64'(ready), 64'd1);
        a        = ta;
        b        = tb;
        alu_ctl  = tc;
        start    = 1'b1;
        last_exp = model(ta, tb, tc);
        sb.push_back(last_exp);
        pushed++;
        @(negedge clk);
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        alu_ctl = 4'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(WIDTH + 1));
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tc);
        int lat;
        issue(ta, tb, tc);
        check("ready_in_run", 64'(ready), 64'd0);
        wait_done(lat);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("ready_after_done", 64'(ready), 64'd1);
        check("result_held", 64'(result), 64'(last_exp.result));
    endtask

    initial begin
        int lat;
        int n;
        int dc;
        reset   = 1'b1;
        start   = 1'b1;
        a       = '0;
        b       = '0;
        alu_ctl = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_zero", 64'(zero), 64'd1);
        check("reset_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run_op(32'h0000_0005, 32'h0000_0003, CTL_ADD);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, CTL_SUB);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, CTL_SLT);
        run_op(32'hFFFF_FFFE, 32'h0000_0001, CTL_SLT);
        run_op(32'h1234_5678, 32'h1234_5678, CTL_SUB);
        run_op(32'hF0F0_F0F0, 32'h0F0F_0000, CTL_NOR);
        run_op(32'hF0F0_F0F0, 32'h0F0F_0000, CTL_AND);
        run_op(32'hF0F0_F0F0, 32'h0F0F_0000, CTL_OR);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, CTL_ADD);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, CTL_ADD);
        run_op(32'h8000_0000, 32'h8000_0000, CTL_AND);
        for (int i = 0; i < 4; i++) run_op($urandom, $urandom, 4'($urandom));

        // A start pulse during RUN must be dropped, not queued.
        dc = done_count;
        issue(32'h0000_1000, 32'h0000_0234, CTL_ADD);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 40) @(negedge clk);
        check("mid_run_start_ignored", 64'(done_count), 64'(dc + 1));

        // start held high: back-to-back ops every WIDTH+2 cycles.
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (ready !== 1'b1 && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            check("held_ready", 64'(ready), 64'd1);
            a        = 32'h0101_0101 * (k + 1);
            b        = 32'h0000_00FF << k;
            alu_ctl  = (k == 1) ? CTL_SUB : CTL_ADD;
            start    = 1'b1;
            sb.push_back(model(a, b, alu_ctl));
            pushed++;
            @(negedge clk);
            a       = $urandom;
            b       = $urandom;
            alu_ctl = 4'($urandom);
        end
        wait_done(lat);
        start = 1'b0;
        check("held_interval", 64'(done_interval), 64'(WIDTH + 2));
        @(negedge clk);

        // Reset while bit 10 is in flight aborts the op with no done pulse.
        dc = done_count;
        issue(32'h0F00_00F0, 32'h0000_7777, CTL_ADD);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        pushed--;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_result", 64'(result), 64'd0);
        check("abort_zero", 64'(zero), 64'd1);
        check("abort_overflow", 64'(overflow), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (WIDTH + 5) @(negedge clk);
        check("abort_no_done", 64'(done_count), 64'(dc));
        run_op(32'h0F00_00F0, 32'h0000_7777, CTL_ADD);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("done_total", 64'(done_count), 64'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
